ysyx_24100005_mem_arbiter: RTL and testbench

- Shares the core's single memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Accepts one transaction at a time from either requester over valid/ready handshakes and issues it to the memory side.
- Waits for the memory response and routes it back to the requester that owns the transaction.
- Sits between the IFU/LSU and the DPI-C memory model wrapper, replacing direct combinational memory calls with a sequenced, multi-cycle access.

---
 rtl/ysyx_24100005_mem_arbiter.sv | 109 ++++++++++
 tb/tb_ysyx_24100005_mem_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100005_mem_arbiter.sv
// ysyx_24100005_mem_arbiter: serializes IFU/LSU requests onto one memory port (LSU has priority).
// Define ARB_TIMEOUT_EN to answer with an error after TIMEOUT silent response cycles.
module ysyx_24100005_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_resp_valid,
   output logic [DATA_W-1:0] ifu_rdata,
   output logic              ifu_resp_err,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic              lsu_wen,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [7:0]        lsu_wmask,
   output logic              lsu_resp_valid,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              lsu_resp_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [7:0]        mem_wmask,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_resp_err
);
   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   state_t state;
   logic owner;
   logic tmo;
   logic ifu_go;
   logic lsu_go;
   logic done;
   assign lsu_req_ready = state == IDLE;
   assign ifu_req_ready = state == IDLE && !lsu_req_valid;
   assign lsu_go = lsu_req_valid && lsu_req_ready;
   assign ifu_go = ifu_req_valid && ifu_req_ready;
   assign done = state == RESP && (mem_resp_valid || tmo);
`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
   assign tmo = state == RESP && cnt == CW'(TIMEOUT - 1);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt <= '0;
      else cnt <= (state == RESP && !mem_resp_valid) ? cnt + 1'b1 : '0;
   end
`else
   logic unused_timeout;
   assign tmo = 1'b0;
   assign unused_timeout = |TIMEOUT;
`endif
   // The latched request fields drive the memory port directly, so they stay stable through REQ.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         owner          <= 1'b0;
         mem_req_valid  <= 1'b0;
         mem_addr       <= '0;
         mem_wen        <= 1'b0;
         mem_wdata      <= '0;
         mem_wmask      <= '0;
         ifu_resp_valid <= 1'b0;
         ifu_rdata      <= '0;
         ifu_resp_err   <= 1'b0;
         lsu_resp_valid <= 1'b0;
         lsu_rdata      <= '0;
         lsu_resp_err   <= 1'b0;
      end else begin
         ifu_resp_valid <= 1'b0;
         lsu_resp_valid <= 1'b0;
         case (state)
            IDLE: if (lsu_go || ifu_go) begin
               state         <= REQ;
               owner         <= lsu_go;
               mem_req_valid <= 1'b1;
               mem_addr      <= lsu_go ? lsu_addr : ifu_addr;
               mem_wen       <= lsu_go && lsu_wen;
               mem_wdata     <= lsu_go ? lsu_wdata : '0;
               mem_wmask     <= lsu_go ? lsu_wmask : '0;
            end
            REQ: if (mem_req_ready) begin
               state         <= RESP;
               mem_req_valid <= 1'b0;
            end
            RESP: if (done) begin
               state <= IDLE;
               if (owner) begin
                  lsu_resp_valid <= 1'b1;
                  lsu_rdata      <= (mem_resp_valid && !mem_wen) ? mem_rdata : '0;
                  lsu_resp_err   <= !mem_resp_valid || mem_resp_err;
               end else begin
                  ifu_resp_valid <= 1'b1;
                  ifu_rdata      <= mem_resp_valid ? mem_rdata : '0;
                  ifu_resp_err   <= !mem_resp_valid || mem_resp_err;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// tb_ysyx_24100005_mem_arbiter: directed scenarios plus randomized transactions against a rule-based model.
module tb_ysyx_24100005_mem_arbiter;
   logic clk = 0;
   logic rst = 1;
   logic ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
   logic [31:0] ifu_addr, ifu_rdata;
   logic lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [7:0] lsu_wmask, mem_wmask;
   logic mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ysyx_24100005_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
   );

   // Inputs change 1 time unit after the rising edge; outputs are observed on the falling edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic obs;
      @(negedge clk);
   endtask

   task automatic clear_inputs;
      ifu_req_valid = 0; ifu_addr = 0;
      lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0; mem_resp_err = 0;
   endtask

   task automatic do_reset;
      clear_inputs();
      rst = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1;
   endtask

   task automatic test_reset;
      clear_inputs();
      #1 rst = 0;
      obs();
      n_checks++;
      if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b exp 00000",
                  {mem_req_valid, ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err});
      end
      n_checks++;
      if ({ifu_rdata, lsu_rdata, mem_addr, mem_wdata, mem_wmask, mem_wen} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got %h %h %h %h %h %b exp all 0",
                  ifu_rdata, lsu_rdata, mem_addr, mem_wdata, mem_wmask, mem_wen);
      end
      n_checks++;
      if ({lsu_req_ready, ifu_req_ready} !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_ready: got %b exp 11", {lsu_req_ready, ifu_req_ready});
      end
      @(posedge clk);
      #1 rst = 1;
   endtask

   task automatic test_lsu_read;
      lsu_req_valid = 1; lsu_addr = 32'h8000_0010; lsu_wen = 0; mem_req_ready = 1;
      tick();
      lsu_req_valid = 0;
      obs();
      n_checks++;
      if ({mem_req_valid, mem_addr, mem_wen} !== {1'b1, 32'h8000_0010, 1'b0}) begin
         n_fail++;
         $display("FAIL lsu_read_issue: got v=%b a=%h w=%b exp v=1 a=80000010 w=0",
                  mem_req_valid, mem_addr, mem_wen);
      end
      tick();
      mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
      obs();
      n_checks++;
      if ({mem_req_valid, lsu_resp_valid, ifu_resp_valid} !== 3'b0) begin
         n_fail++;
         $display("FAIL lsu_read_early: got %b exp 000", {mem_req_valid, lsu_resp_valid, ifu_resp_valid});
      end
      tick();
      mem_resp_valid = 0; mem_rdata = 32'hFFFF_FFFF;
      obs();
      n_checks++;
      if ({lsu_resp_valid, ifu_resp_valid, lsu_rdata, lsu_resp_err} !== {2'b10, 32'h1234_5678, 1'b0}) begin
         n_fail++;
         $display("FAIL lsu_read_resp: got lv=%b iv=%b d=%h e=%b exp lv=1 iv=0 d=12345678 e=0",
                  lsu_resp_valid, ifu_resp_valid, lsu_rdata, lsu_resp_err);
      end
      tick();
      obs();
      n_checks++;
      if ({lsu_resp_valid, lsu_rdata} !== {1'b0, 32'h1234_5678}) begin
         n_fail++;
         $display("FAIL lsu_read_hold: got v=%b d=%h exp v=0 d=12345678", lsu_resp_valid, lsu_rdata);
      end
      mem_req_ready = 0;
   endtask

   task automatic test_priority;
      tick();
      ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
      lsu_req_valid = 1; lsu_addr = 32'h8000_0100; lsu_wen = 0; mem_req_ready = 1;
      obs();
      n_checks++;
      if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL prio_ready: got %b exp 10", {lsu_req_ready, ifu_req_ready});
      end
      tick();
      lsu_req_valid = 0;
      obs();
      n_checks++;
      if ({mem_req_valid, mem_addr, ifu_req_ready} !== {1'b1, 32'h8000_0100, 1'b0}) begin
         n_fail++;
         $display("FAIL prio_first: got v=%b a=%h ir=%b exp v=1 a=80000100 ir=0",
                  mem_req_valid, mem_addr, ifu_req_ready);
      end
      tick();
      mem_resp_valid = 1; mem_rdata = 32'hA1A1_0001;
      tick();
      mem_resp_valid = 0;
      obs();
      n_checks++;
      if ({lsu_resp_valid, ifu_resp_valid, ifu_req_ready, lsu_rdata} !== {3'b101, 32'hA1A1_0001}) begin
         n_fail++;
         $display("FAIL prio_lsu_done: got lv=%b iv=%b ir=%b d=%h exp lv=1 iv=0 ir=1 d=a1a10001",
                  lsu_resp_valid, ifu_resp_valid, ifu_req_ready, lsu_rdata);
      end
      tick();
      ifu_req_valid = 0;
      obs();
      n_checks++;
      if ({mem_req_valid, mem_addr, mem_wen, mem_wmask} !== {1'b1, 32'h8000_0000, 1'b0, 8'h00}) begin
         n_fail++;
         $display("FAIL prio_second: got v=%b a=%h w=%b m=%h exp v=1 a=80000000 w=0 m=00",
                  mem_req_valid, mem_addr, mem_wen, mem_wmask);
      end
      tick();
      mem_resp_valid = 1; mem_rdata = 32'hB2B2_0002;
      tick();
      mem_resp_valid = 0;
      obs();
      n_checks++;
      if ({ifu_resp_valid, lsu_resp_valid, ifu_rdata} !== {2'b10, 32'hB2B2_0002}) begin
         n_fail++;
         $display("FAIL prio_ifu_done: got iv=%b lv=%b d=%h exp iv=1 lv=0 d=b2b20002",
                  ifu_resp_valid, lsu_resp_valid, ifu_rdata);
      end
      mem_req_ready = 0;
   endtask

   task automatic test_write_stall;
      tick();
      lsu_req_valid = 1; lsu_addr = 32'h8000_0200; lsu_wen = 1;
      lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F; mem_req_ready = 0;
      tick();
      lsu_req_valid = 0; lsu_addr = 32'h1111_1111; lsu_wdata = 32'h2222_2222; lsu_wmask = 8'hF0; lsu_wen = 0;
      for (int k = 0; k < 4; k++) begin
         mem_req_ready = k == 3;
         obs();
         n_checks++;
         if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !==
             {1'b1, 32'h8000_0200, 1'b1, 32'hDEAD_BEEF, 8'h0F}) begin
            n_fail++;
            $display("FAIL write_hold%0d: got v=%b a=%h w=%b d=%h m=%h exp v=1 a=80000200 w=1 d=deadbeef m=0f",
                     k, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask);
         end
         tick();
      end
      mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'hAAAA_5555;
      tick();
      mem_resp_valid = 0;
      obs();
      n_checks++;
      if ({lsu_resp_valid, lsu_rdata, lsu_resp_err} !== {1'b1, 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL write_resp: got v=%b d=%h e=%b exp v=1 d=0 e=0", lsu_resp_valid, lsu_rdata, lsu_resp_err);
      end
   endtask

   task automatic test_reset_mid;
      tick();
      lsu_req_valid = 1; lsu_addr = 32'h8000_0300; lsu_wen = 0; mem_req_ready = 1;
      tick();
      lsu_req_valid = 0;
      tick();
      mem_req_ready = 0;
      obs();
      #2 rst = 0;
      #1;
      n_checks++;
      if ({ifu_rdata, lsu_req_ready, mem_req_valid} !== {32'h0, 2'b10}) begin
         n_fail++;
         $display("FAIL async_reset: got d=%h lr=%b mv=%b exp d=0 lr=1 mv=0", ifu_rdata, lsu_req_ready, mem_req_valid);
      end
      @(posedge clk);
      #1 rst = 1;
      mem_resp_valid = 1; mem_rdata = 32'h5555_AAAA;
      tick();
      mem_resp_valid = 0;
      obs();
      n_checks++;
      if ({ifu_resp_valid, lsu_resp_valid, mem_req_valid, lsu_req_ready, ifu_rdata, lsu_rdata} !== {4'b0001, 64'h0}) begin
         n_fail++;
         $display("FAIL reset_drop: got iv=%b lv=%b mv=%b lr=%b id=%h ld=%h exp iv=0 lv=0 mv=0 lr=1 id=0 ld=0",
                  ifu_resp_valid, lsu_resp_valid, mem_req_valid, lsu_req_ready, ifu_rdata, lsu_rdata);
      end
   endtask

   task automatic test_ifu_err;
      tick();
      ifu_req_valid = 1; ifu_addr = 32'h8000_0040; mem_req_ready = 1;
      tick();
      ifu_req_valid = 0;
      tick();
      mem_req_ready = 0; mem_resp_valid = 1; mem_resp_err = 1; mem_rdata = 32'h0BAD_0BAD;
      tick();
      mem_resp_valid = 0; mem_resp_err = 0;
      obs();
      n_checks++;
      if ({ifu_resp_valid, ifu_resp_err, lsu_resp_valid, ifu_rdata} !== {3'b110, 32'h0BAD_0BAD}) begin
         n_fail++;
         $display("FAIL ifu_err: got v=%b e=%b lv=%b d=%h exp v=1 e=1 lv=0 d=0bad0bad",
                  ifu_resp_valid, ifu_resp_err, lsu_resp_valid, ifu_rdata);
      end
   endtask

   // Model: LSU is served before a simultaneous IFU request, reads return the memory word,
   // writes return 0, each requester's rdata/err hold their last response.
   task automatic test_random;
      logic [31:0] ia, la, lw, rd, exp_a;
      logic [7:0] lm, exp_m;
      logic lwen, er, o, exp_w;
      logic [31:0] hold_rd [2];
      logic hold_err [2];
      bit own [$];
      int sel, r, d;
      do_reset();
      hold_rd[0] = 0; hold_rd[1] = 0; hold_err[0] = 0; hold_err[1] = 0;
      for (int it = 0; it < 80; it++) begin
         sel = int'($urandom_range(2));
         ia = $urandom; la = $urandom; lw = $urandom; lm = 8'($urandom); lwen = 1'($urandom);
         own.delete();
         if (sel != 0) own.push_back(1);
         if (sel != 1) own.push_back(0);
         ifu_req_valid = sel != 1; ifu_addr = ia;
         lsu_req_valid = sel != 0; lsu_addr = la; lsu_wen = lwen; lsu_wdata = lw; lsu_wmask = lm;
         mem_resp_valid = 0;
         obs();
         n_checks++;
         if ({lsu_req_ready, ifu_req_ready, ifu_resp_valid, lsu_resp_valid} !== {1'b1, sel == 0, 2'b00}) begin
            n_fail++;
            $display("FAIL rnd_idle it%0d: got lr=%b ir=%b iv=%b lv=%b exp lr=1 ir=%b iv=0 lv=0",
                     it, lsu_req_ready, ifu_req_ready, ifu_resp_valid, lsu_resp_valid, sel == 0);
         end
         n_checks++;
         if ({ifu_rdata, ifu_resp_err, lsu_rdata, lsu_resp_err} !== {hold_rd[0], hold_err[0], hold_rd[1], hold_err[1]}) begin
            n_fail++;
            $display("FAIL rnd_hold it%0d: got %h %b %h %b exp %h %b %h %b", it, ifu_rdata, ifu_resp_err,
                     lsu_rdata, lsu_resp_err, hold_rd[0], hold_err[0], hold_rd[1], hold_err[1]);
         end
         tick();
         for (int j = 0; j < own.size(); j++) begin
            o = own[j];
            if (o) lsu_req_valid = 0;
            else ifu_req_valid = 0;
            exp_a = o ? la : ia;
            exp_w = o & lwen;
            exp_m = o ? lm : 8'h00;
            r = int'($urandom_range(3));
            for (int k = 0; k <= r; k++) begin
               mem_req_ready = k == r; mem_resp_valid = 1'($urandom); mem_rdata = $urandom;
               obs();
               n_checks++;
               if ({mem_req_valid, mem_addr, mem_wen, mem_wmask, lsu_req_ready, ifu_req_ready,
                    ifu_resp_valid, lsu_resp_valid} !== {1'b1, exp_a, exp_w, exp_m, 4'b0} ||
                   (o && mem_wdata !== lw)) begin
                  n_fail++;
                  $display("FAIL rnd_req it%0d: got v=%b a=%h w=%b m=%h d=%h rdy=%b%b rv=%b%b exp v=1 a=%h w=%b m=%h d=%h rdy=00 rv=00",
                           it, mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata, lsu_req_ready,
                           ifu_req_ready, ifu_resp_valid, lsu_resp_valid, exp_a, exp_w, exp_m, lw);
               end
               tick();
            end
            mem_req_ready = 0;
            d = int'($urandom_range(3));
            rd = $urandom;
            er = ($urandom % 4) == 0;
            for (int k = 0; k <= d; k++) begin
               mem_resp_valid = k == d;
               mem_rdata = (k == d) ? rd : $urandom;
               mem_resp_err = (k == d) ? er : 1'($urandom);
               obs();
               n_checks++;
               if ({mem_req_valid, lsu_req_ready, ifu_req_ready, ifu_resp_valid, lsu_resp_valid} !== 5'b0) begin
                  n_fail++;
                  $display("FAIL rnd_wait it%0d: got mv=%b rdy=%b%b rv=%b%b exp all 0", it, mem_req_valid,
                           lsu_req_ready, ifu_req_ready, ifu_resp_valid, lsu_resp_valid);
               end
               tick();
            end
            mem_resp_valid = 1'($urandom); mem_rdata = $urandom; mem_resp_err = 1'($urandom);
            hold_rd[o] = exp_w ? 32'h0 : rd;
            hold_err[o] = er;
            obs();
            n_checks++;
            if ({ifu_resp_valid, lsu_resp_valid} !== (o ? 2'b01 : 2'b10) ||
                {ifu_rdata, ifu_resp_err, lsu_rdata, lsu_resp_err} !== {hold_rd[0], hold_err[0], hold_rd[1], hold_err[1]}) begin
               n_fail++;
               $display("FAIL rnd_resp it%0d: got iv=%b lv=%b %h %b %h %b exp owner_lsu=%b %h %b %h %b", it,
                        ifu_resp_valid, lsu_resp_valid, ifu_rdata, ifu_resp_err, lsu_rdata, lsu_resp_err,
                        o, hold_rd[0], hold_err[0], hold_rd[1], hold_err[1]);
            end
            if (j + 1 < own.size()) begin
               n_checks++;
               if (ifu_req_ready !== 1'b1) begin
                  n_fail++;
                  $display("FAIL rnd_regrant it%0d: got ir=%b exp 1", it, ifu_req_ready);
               end
            end
            tick();
         end
      end
      clear_inputs();
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout;
      do_reset();
      lsu_req_valid = 1; lsu_addr = 32'h8000_0500; lsu_wen = 0; mem_req_ready = 1;
      tick();
      lsu_req_valid = 0;
      tick();
      mem_req_ready = 0;
      for (int k = 0; k < 4; k++) begin
         obs();
         n_checks++;
         if (lsu_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early%0d: got %b exp 0", k, lsu_resp_valid);
         end
         tick();
      end
      lsu_req_valid = 1; lsu_addr = 32'h8000_0600;
      obs();
      n_checks++;
      if ({lsu_resp_valid, lsu_resp_err, lsu_rdata, lsu_req_ready} !== {2'b11, 32'h0, 1'b1}) begin
         n_fail++;
         $display("FAIL timeout_resp: got v=%b e=%b d=%h r=%b exp v=1 e=1 d=0 r=1",
                  lsu_resp_valid, lsu_resp_err, lsu_rdata, lsu_req_ready);
      end
      tick();
      lsu_req_valid = 0;
      obs();
      n_checks++;
      if ({mem_req_valid, mem_addr} !== {1'b1, 32'h8000_0600}) begin
         n_fail++;
         $display("FAIL timeout_next: got v=%b a=%h exp v=1 a=80000600", mem_req_valid, mem_addr);
      end
      do_reset();
   endtask
`endif

   initial begin
      test_reset();
      test_lsu_read();
      test_priority();
      test_write_stall();
      test_reset_mid();
      test_ifu_err();
      test_random();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
